// File: rtl/box_pkg.sv
// Shared types and helpers for the box overlay front-end controller.
// Direction vectors are ordered {right, left, down, up}, with up in bit 0.
package box_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int BTN_CENTER = 4;

  // Fixed priority: up > down > left > right.
  function automatic dir_t grant_dir(input logic [3:0] lvl);
    dir_t d;
    if (lvl[0])      d = DIR_UP;
    else if (lvl[1]) d = DIR_DOWN;
    else if (lvl[2]) d = DIR_LEFT;
    else if (lvl[3]) d = DIR_RIGHT;
    else             d = DIR_NONE;
    return d;
  endfunction

  function automatic logic [3:0] dir_onehot(input dir_t d);
    logic [3:0] v;
    case (d)
      DIR_UP:    v = 4'b0001;
      DIR_DOWN:  v = 4'b0010;
      DIR_LEFT:  v = 4'b0100;
      DIR_RIGHT: v = 4'b1000;
      default:   v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a hold-time debouncer for one raw button.
// The rise output pulses for one cycle in the first cycle the stable level reads 1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;

  // Synchronize, then accept a new level only after it has held long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= '0;
      stable  <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      rise    <= 1'b0;
      if (sync2_r == stable) begin
        cnt_r <= '0;
      end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2_r;
        rise   <= sync2_r;
        cnt_r  <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/box_ctrl.sv
// Button front-end: debounces five buttons, grants one direction at a time,
// and issues single-cycle step pulses with auto-repeat plus a mode toggle.
module box_ctrl
  import box_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_center,
  output logic move_up,
  output logic move_down,
  output logic move_left,
  output logic move_right,
  output logic mode,
  output logic repeating
);

  logic [4:0]       raw_s;
  logic [4:0]       stable_s;
  logic [4:0]       rise_s;
  logic             unused_rise_s;

  state_t           state_r, next_state_s;
  dir_t             owner_r, next_owner_s;
  logic [CNT_W-1:0] cnt_r, next_cnt_s;
  logic [3:0]       move_r, next_move_s;
  logic             next_mode_s;
  logic             owner_lvl_s;
  dir_t             grant_s;

  assign raw_s = {btn_center, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (raw_s[i]),
      .stable (stable_s[i]),
      .rise   (rise_s[i])
    );
  end

  // Only the center button is edge-sensitive; directions act on levels.
  assign unused_rise_s = ^rise_s[3:0];
  assign owner_lvl_s   = |(dir_onehot(owner_r) & stable_s[3:0]);
  assign grant_s       = grant_dir(stable_s[3:0]);

  // Next-state, shared counter and pulse generation; release beats a due pulse.
  always_comb begin
    next_state_s = state_r;
    next_owner_s = owner_r;
    next_cnt_s   = cnt_r;
    next_move_s  = 4'b0000;
    next_mode_s  = mode;
    case (state_r)
      IDLE: begin
        if (rise_s[BTN_CENTER]) next_mode_s = ~mode;
        else                    next_mode_s = mode;
        if (grant_s != DIR_NONE) begin
          next_owner_s = grant_s;
          next_move_s  = dir_onehot(grant_s);
          next_state_s = DELAY;
          next_cnt_s   = CNT_W'(REPEAT_DELAY - 1);
        end else begin
          next_owner_s = DIR_NONE;
        end
      end
      DELAY, REPEAT: begin
        if (!owner_lvl_s) begin
          next_state_s = IDLE;
          next_owner_s = DIR_NONE;
        end else if (cnt_r == '0) begin
          next_move_s  = dir_onehot(owner_r);
          next_state_s = REPEAT;
          next_cnt_s   = CNT_W'(REPEAT_PERIOD - 1);
        end else begin
          next_cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        next_state_s = IDLE;
        next_owner_s = DIR_NONE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      owner_r   <= DIR_NONE;
      cnt_r     <= '0;
      move_r    <= 4'b0000;
      mode      <= 1'b1;
      repeating <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      owner_r   <= next_owner_s;
      cnt_r     <= next_cnt_s;
      move_r    <= next_move_s;
      mode      <= next_mode_s;
      repeating <= (next_state_s == REPEAT);
    end
  end

  assign move_up    = move_r[0];
  assign move_down  = move_r[1];
  assign move_left  = move_r[2];
  assign move_right = move_r[3];

endmodule
